// File: rtl/pa_cpu.sv
`default_nettype none
// ============================================================================
// Module      : pa_cpu (package)
// Description : Shared constants, interrupt-controller FSM state type and a
//               lowest-set-bit priority helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pa_cpu;

  localparam int NBR_IRQS = 8;
  localparam int c_ID_W   = $clog2(NBR_IRQS);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } e_int_ctrl_state;

  // Bit 0 has the highest priority, so the lowest set index wins.
  function automatic logic [c_ID_W-1:0] f_lowest_set(input logic [NBR_IRQS-1:0] v);
    logic [c_ID_W-1:0] id;
    id = '0;
    for (int i = NBR_IRQS - 1; i >= 0; i--) begin
      if (v[i]) id = i[c_ID_W-1:0];
    end
    return id;
  endfunction

endpackage
`default_nettype wire

// File: rtl/irq_edge_detector.sv
`default_nettype none
// ============================================================================
// Module      : irq_edge_detector
// Description : One interrupt line: optional two-flop synchroniser (enabled by
//               the IRQ_SYNC_EN macro) followed by a rising-edge pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_edge_detector (
  input  logic clk,
  input  logic arst,
  input  logic i_irq,
  output logic o_edge
);

  logic w_line;
  logic r_prev;

`ifdef IRQ_SYNC_EN
  logic r_sync1;
  logic r_sync2;

  // Two-flop synchroniser for an asynchronous external line.
  always_ff @(posedge clk) begin
    if (arst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_irq;
      r_sync2 <= r_sync1;
    end
  end

  assign w_line = r_sync2;
`else
  assign w_line = i_irq;
`endif

  // Previous-cycle copy of the line for rising-edge detection.
  always_ff @(posedge clk) begin
    if (arst) r_prev <= 1'b0;
    else      r_prev <= w_line;
  end

  assign o_edge = w_line & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/interrupt_controller.sv
`default_nettype none
// ============================================================================
// Module      : interrupt_controller
// Description : 8-line edge-triggered, maskable, fixed-priority interrupt
//               controller with IDLE/REQ/SERVICE handshake FSM.
//               Optional macro IRQ_SYNC_EN adds a two-flop synchroniser on
//               each irq_in line (request latency +2 cycles).
// Revision    : 1.0 - initial release
// ============================================================================
module interrupt_controller
  import pa_cpu::*;
(
  input  logic                clk,
  input  logic                arst,
  input  logic [NBR_IRQS-1:0] irq_in,
  input  logic                status_irq_en,
  input  logic [7:0]          z_bus,
  input  logic                ctrl_irq_masks_wrt,
  input  logic                ctrl_int_vector_wrt,
  input  logic                ctrl_int_ack,
  input  logic                ctrl_clear_all_ints,
  output logic                int_pending,
  output logic [7:0]          int_vector,
  output logic [7:0]          irq_masks,
  output logic [7:0]          irq_status
);

  e_int_ctrl_state     r_state;
  e_int_ctrl_state     w_state_nxt;
  logic [NBR_IRQS-1:0] w_edges;
  logic [NBR_IRQS-1:0] r_pending;
  logic [NBR_IRQS-1:0] w_pending_nxt;
  logic [NBR_IRQS-1:0] r_masks;
  logic [NBR_IRQS-1:0] w_eligible;
  logic [c_ID_W-1:0]   w_sel_id;
  logic [c_ID_W-1:0]   r_id;
  logic                w_ack_ok;
  logic                w_vec_ok;

  genvar gi;
  generate
    for (gi = 0; gi < NBR_IRQS; gi++) begin : g_lines
      irq_edge_detector u_edge (
        .clk    (clk),
        .arst   (arst),
        .i_irq  (irq_in[gi]),
        .o_edge (w_edges[gi])
      );
    end
  endgenerate

  assign w_eligible = r_pending & r_masks;
  assign w_sel_id   = f_lowest_set(w_eligible);
  assign w_ack_ok   = (r_state == ST_SERVICE) && ctrl_int_ack;
  assign w_vec_ok   = (r_state == ST_REQ) && ctrl_int_vector_wrt && (w_eligible != '0);

  // Pending next value: ack clears the serviced bit, but a new edge on the
  // same line in the same cycle is OR-ed in afterwards and therefore wins.
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_ack_ok) w_pending_nxt[r_id] = 1'b0;
    w_pending_nxt = w_pending_nxt | w_edges;
  end

  // Pending register; clear-all overrides edges and ack.
  always_ff @(posedge clk) begin
    if (arst || ctrl_clear_all_ints) r_pending <= '0;
    else                             r_pending <= w_pending_nxt;
  end

  // Mask register, untouched by clear-all.
  always_ff @(posedge clk) begin
    if (arst)                    r_masks <= '0;
    else if (ctrl_irq_masks_wrt) r_masks <= z_bus;
  end

  // Latched vector id; held through SERVICE and after ack.
  always_ff @(posedge clk) begin
    if (arst)                                 r_id <= '0;
    else if (w_vec_ok && !ctrl_clear_all_ints) r_id <= w_sel_id;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (arst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    if (ctrl_clear_all_ints) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_eligible != '0) w_state_nxt = ST_REQ;
        end
        ST_REQ: begin
          if (w_eligible == '0)         w_state_nxt = ST_IDLE;
          else if (ctrl_int_vector_wrt) w_state_nxt = ST_SERVICE;
        end
        ST_SERVICE: begin
          if (ctrl_int_ack) w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign int_pending = (r_state == ST_REQ) & status_irq_en;
  assign int_vector  = {{(8 - c_ID_W){1'b0}}, r_id};
  assign irq_masks   = r_masks;
  assign irq_status  = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_interrupt_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_interrupt_controller
// Description : Scoreboard bench for interrupt_controller. Stimulus pushes
//               hand-computed expected outputs; a monitor pops and compares
//               on the falling edge. Honours IRQ_SYNC_EN for latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_interrupt_controller;

`ifdef IRQ_SYNC_EN
  localparam int L = 2;
`else
  localparam int L = 0;
`endif

  logic       clk = 1'b0;
  logic       arst;
  logic [7:0] irq_in;
  logic       status_irq_en;
  logic [7:0] z_bus;
  logic       ctrl_irq_masks_wrt;
  logic       ctrl_int_vector_wrt;
  logic       ctrl_int_ack;
  logic       ctrl_clear_all_ints;
  logic       int_pending;
  logic [7:0] int_vector;
  logic [7:0] irq_masks;
  logic [7:0] irq_status;

  typedef struct {
    string      name;
    logic       ip;
    logic [7:0] vec;
    logic [7:0] msk;
    logic [7:0] sts;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  interrupt_controller dut (
    .clk                 (clk),
    .arst                (arst),
    .irq_in              (irq_in),
    .status_irq_en       (status_irq_en),
    .z_bus               (z_bus),
    .ctrl_irq_masks_wrt  (ctrl_irq_masks_wrt),
    .ctrl_int_vector_wrt (ctrl_int_vector_wrt),
    .ctrl_int_ack        (ctrl_int_ack),
    .ctrl_clear_all_ints (ctrl_clear_all_ints),
    .int_pending         (int_pending),
    .int_vector          (int_vector),
    .irq_masks           (irq_masks),
    .irq_status          (irq_status)
  );

  always #5 clk = ~clk;

  // Monitor: compare every queued expectation at the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        n_checks++;
        if (int_pending === e.ip && int_vector === e.vec &&
            irq_masks === e.msk && irq_status === e.sts) begin
          n_pass++;
        end else begin
          $display("FAIL %s: got ip=%b vec=%h msk=%h sts=%h, want ip=%b vec=%h msk=%h sts=%h",
                   e.name, int_pending, int_vector, irq_masks, irq_status,
                   e.ip, e.vec, e.msk, e.sts);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic ip, input logic [7:0] vec,
                     input logic [7:0] msk, input logic [7:0] sts);
    exp_t e;
    e.name = name; e.ip = ip; e.vec = vec; e.msk = msk; e.sts = sts;
    q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic wr_mask(input logic [7:0] m);
    z_bus = m; ctrl_irq_masks_wrt = 1'b1;
    tick();
    ctrl_irq_masks_wrt = 1'b0;
  endtask

  task automatic vec_wrt();
    ctrl_int_vector_wrt = 1'b1;
    tick();
    ctrl_int_vector_wrt = 1'b0;
  endtask

  task automatic ack();
    ctrl_int_ack = 1'b1;
    tick();
    ctrl_int_ack = 1'b0;
  endtask

  task automatic settle();
    repeat (4) tick();
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    arst = 1'b1; irq_in = '0; status_irq_en = 1'b1; z_bus = '0;
    ctrl_irq_masks_wrt = 1'b0; ctrl_int_vector_wrt = 1'b0;
    ctrl_int_ack = 1'b0; ctrl_clear_all_ints = 1'b0;
    tick(); tick();
    arst = 1'b0;
    chk("reset", 1'b0, 8'h00, 8'h00, 8'h00);

    // Single request on line 3, including latency.
    wr_mask(8'h08);
    chk("mask08", 1'b0, 8'h00, 8'h08, 8'h00);
    irq_in = 8'h08;
    repeat (L + 1) tick();
    chk("edge_latency", 1'b0, 8'h00, 8'h08, 8'h08);
    tick();
    chk("req_line3", 1'b1, 8'h00, 8'h08, 8'h08);
    status_irq_en = 1'b0;
    #1;
    chk("irq_en_gate", 1'b0, 8'h00, 8'h08, 8'h08);
    status_irq_en = 1'b1;
    vec_wrt();
    chk("vector3", 1'b0, 8'h03, 8'h08, 8'h08);
    irq_in = 8'h00;
    ack();
    chk("ack3", 1'b0, 8'h03, 8'h08, 8'h00);
    tick();
    chk("idle_after_ack3", 1'b0, 8'h03, 8'h08, 8'h00);
    settle();

    // Simultaneous edges on lines 5 and 2.
    wr_mask(8'hFF);
    irq_in = 8'h24;
    repeat (L + 2) tick();
    chk("req_5_2", 1'b1, 8'h03, 8'hFF, 8'h24);
    vec_wrt();
    chk("vector2", 1'b0, 8'h02, 8'hFF, 8'h24);
    ack();
    chk("ack2", 1'b0, 8'h02, 8'hFF, 8'h20);
    tick();
    chk("rereq5", 1'b1, 8'h02, 8'hFF, 8'h20);
    vec_wrt();
    chk("vector5", 1'b0, 8'h05, 8'hFF, 8'h20);
    irq_in = 8'h00;
    ack();
    chk("ack5", 1'b0, 8'h05, 8'hFF, 8'h00);
    settle();

    // Held level raises one request only.
    wr_mask(8'h02);
    irq_in = 8'h02;
    repeat (L + 2) tick();
    chk("req1", 1'b1, 8'h05, 8'h02, 8'h02);
    vec_wrt();
    chk("vector1", 1'b0, 8'h01, 8'h02, 8'h02);
    ack();
    chk("ack1", 1'b0, 8'h01, 8'h02, 8'h00);
    repeat (20) tick();
    chk("held_level_once", 1'b0, 8'h01, 8'h02, 8'h00);
    irq_in = 8'h00;
    settle();

    // Masked pending bits, then unmask line 7.
    wr_mask(8'h00);
    irq_in = 8'h81;
    repeat (L + 2) tick();
    chk("masked_81", 1'b0, 8'h01, 8'h00, 8'h81);
    wr_mask(8'h80);
    chk("mask80_edge", 1'b0, 8'h01, 8'h80, 8'h81);
    tick();
    chk("req7", 1'b1, 8'h01, 8'h80, 8'h81);
    vec_wrt();
    chk("vector7", 1'b0, 8'h07, 8'h80, 8'h81);
    irq_in = 8'h00;
    ack();
    chk("ack7", 1'b0, 8'h07, 8'h80, 8'h01);
    tick();
    chk("line0_masked_idle", 1'b0, 8'h07, 8'h80, 8'h01);
    settle();

    // Clear-all coincident with an edge on line 0.
    irq_in = 8'h01;
    repeat (L) tick();
    ctrl_clear_all_ints = 1'b1;
    tick();
    ctrl_clear_all_ints = 1'b0;
    chk("clear_all", 1'b0, 8'h07, 8'h80, 8'h00);
    irq_in = 8'h00;
    settle();

    // Ack coincident with a new edge on the latched line 4.
    wr_mask(8'h10);
    irq_in = 8'h10;
    repeat (L + 2) tick();
    chk("req4", 1'b1, 8'h07, 8'h10, 8'h10);
    vec_wrt();
    chk("vector4", 1'b0, 8'h04, 8'h10, 8'h10);
    irq_in = 8'h00;
    settle();
    chk("service4_hold", 1'b0, 8'h04, 8'h10, 8'h10);
    irq_in = 8'h10;
    repeat (L) tick();
    ack();
    chk("ack_edge_wins", 1'b0, 8'h04, 8'h10, 8'h10);
    tick();
    chk("rereq4", 1'b1, 8'h04, 8'h10, 8'h10);

    // Masking the latched line in SERVICE keeps SERVICE; ack still clears.
    vec_wrt();
    wr_mask(8'h00);
    chk("mask_in_service", 1'b0, 8'h04, 8'h00, 8'h10);
    ack();
    chk("ack_after_mask", 1'b0, 8'h04, 8'h00, 8'h00);
    irq_in = 8'h00;
    settle();

    // Reset in the middle of SERVICE.
    wr_mask(8'h40);
    irq_in = 8'h40;
    repeat (L + 2) tick();
    vec_wrt();
    chk("vector6", 1'b0, 8'h06, 8'h40, 8'h40);
    arst = 1'b1; irq_in = 8'h00;
    tick();
    arst = 1'b0;
    chk("reset_mid_service", 1'b0, 8'h00, 8'h00, 8'h00);
    tick();
    chk("after_reset", 1'b0, 8'h00, 8'h00, 8'h00);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: got %0d entries, want 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
